stopwatch_controller: RTL and testbench
=======================================

// Module: stopwatch_controller
// PURPOSE
//  Sequences the 1 Hz tick divider and owns the mm:ss BCD time count for the stopwatch.
//  Turns start/stop, lap and clear button levels into a run/pause/lap state machine.
//  Holds the divider in reset whenever the watch is not running.
//  Feeds the four 7-segment display digits.
// PARAMETERS
//  MAX_MINUTES   59   highest minute value shown; legal range 1..99
// PORTS
//  clk        in   1  system clock (100 MHz board clock)
//  rst        in   1  synchronous, active-high reset
//  tick       in   1  one-cycle pulse from the tick divider, one per counted second
//  startStop  in   1  debounced button level; a rising edge toggles run/pause
//  lap        in   1  debounced button level; a rising edge toggles lap freeze
//  clear      in   1  debounced button level; a rising edge zeroes the count
//  dividerRst out  1  reset to the tick divider
//  running    out  1  high while in RUN
//  lapActive  out  1  high while the display shows the frozen lap value
//  secOnes    out  4  displayed seconds ones, BCD 0..9
//  secTens    out  4  displayed seconds tens, BCD 0..5
//  minOnes    out  4  displayed minutes ones, BCD 0..9
//  minTens    out  4  displayed minutes tens, BCD 0..9
//  overflow   out  1  limit indication; see CONFIGURATION
// BEHAVIOUR
//  Reset values: state IDLE, live count 00:00, lap latch 00:00, dividerRst=1, all other outputs 0.
//  Edge detect: each button has a previous-level register that resets to 1, so a button
//   held through reset does not fire; edge = level & ~prev.
//  Edge priority on the same cycle: clear > startStop > lap. Only the highest-priority edge acts;
//   the others are dropped.
//  States:
//   IDLE -> startStop -> RUN.
//   RUN  -> startStop -> PAUSE.
//   PAUSE -> startStop -> RUN.
//   RUN/PAUSE/DONE -> clear -> IDLE.
//   RUN -> limit reached -> DONE (saturating build only).
//  clear: from any state, live count, lap latch and lapActive go to 0 and the state goes to IDLE.
//   The outputs show this one cycle after the edge.
//  dividerRst = (next state != RUN), registered. Each resume therefore starts a full period;
//   the partial second at pause is discarded.
//  Counting: only a tick sampled while the state is RUN advances the count.
//   The count updates one cycle after the tick.
//   Carry chain: secOnes 9->0 increments secTens; secTens 5->0 increments minutes.
//   Minutes count 0..MAX_MINUTES as a two-digit BCD value.
//  A tick in the same cycle as any button edge is ignored.
//  lap edge in RUN or PAUSE:
//   - lapActive=0: copy the live count into the lap latch and set lapActive=1.
//   - lapActive=1: clear lapActive.
//   - The live count keeps running in both cases.
//   - lap edges in IDLE or DONE are ignored.
//  Display digits are registered: lapActive ? lap latch : live count.
//  running = (state == RUN), registered.
// CONFIGURATION
//  STOPWATCH_WRAP_EN defined:
//   - A tick at MAX_MINUTES:59 wraps the count to 00:00 and the state stays RUN.
//   - overflow pulses high for exactly one cycle, coincident with the 00:00 update.
//   - The DONE state is unreachable.
//  STOPWATCH_WRAP_EN undefined:
//   - A tick at MAX_MINUTES:59 leaves the count at MAX_MINUTES:59 and enters DONE.
//   - In DONE: dividerRst=1 and running=0; overflow stays high until clear or rst.
// TESTING
//  (Bench drives tick directly with a 1-cycle pulse every 4 clk.)
//  1. rst, startStop edge, 75 ticks -> running=1, dividerRst=0, display 01:15; held button at
//     rst release -> no transition.
//  2. RUN at 00:10, startStop edge, 5 ticks -> PAUSE, display stays 00:10, dividerRst=1;
//     next startStop edge -> RUN, next tick gives 00:11.
//  3. RUN at 00:20, lap edge, 30 ticks -> display 00:20 with lapActive=1; lap edge -> display
//     00:50, lapActive=0.
//  4. clear, startStop and lap edges in the same cycle, plus a tick, while RUN at 02:03 ->
//     IDLE, 00:00, lapActive=0, running=0.
//  5. MAX_MINUTES=1, count at 01:59, tick:
//     - WRAP_EN: 00:00, 1-cycle overflow, RUN.
//     - else: 01:59, DONE, overflow held; further ticks ignored; clear edge -> IDLE, overflow=0.
//  6. rst asserted mid-RUN at 00:42 -> next cycle all outputs at reset values, dividerRst=1.

Source files
------------

// File: rtl/stopwatch_controller.sv
// -----------------------------------------------------------------------------
// stopwatch_controller
//   Run/pause/lap controller and mm:ss BCD time count for the stopwatch.
//   It turns the start/stop, lap and clear button levels into state changes.
//   It holds the tick divider in reset whenever the watch is not running.
//   It drives the four display digits from either the live count or the
//   frozen lap value.
//
//   Compile-time option: define STOPWATCH_WRAP_EN to wrap MAX_MINUTES:59 to
//   00:00 with a one-cycle overflow pulse. When it is undefined, the count
//   saturates at MAX_MINUTES:59 and enters DONE, and overflow stays high.
//
// Parameters
//   MAX_MINUTES  highest minute value shown (1..99)
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   tick       in   one-cycle pulse per counted second
//   startStop  in   button level, rising edge toggles run/pause
//   lap        in   button level, rising edge toggles lap freeze
//   clear      in   button level, rising edge zeroes the count
//   dividerRst out  reset to the tick divider (high unless running)
//   running    out  high while in RUN
//   lapActive  out  high while the display shows the lap value
//   secOnes    out  displayed seconds ones (BCD)
//   secTens    out  displayed seconds tens (BCD)
//   minOnes    out  displayed minutes ones (BCD)
//   minTens    out  displayed minutes tens (BCD)
//   overflow   out  limit indication
// -----------------------------------------------------------------------------
module stopwatch_controller #(
    parameter int MAX_MINUTES = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       startStop,
    input  logic       lap,
    input  logic       clear,
    output logic       dividerRst,
    output logic       running,
    output logic       lapActive,
    output logic [3:0] secOnes,
    output logic [3:0] secTens,
    output logic [3:0] minOnes,
    output logic [3:0] minTens,
    output logic       overflow
);

    localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MINUTES % 10);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state_r, state_nxt_s;
    logic [3:0] so_r, st_r, mo_r, mt_r;
    logic [3:0] so_nxt_s, st_nxt_s, mo_nxt_s, mt_nxt_s;
    logic [3:0] lso_r, lst_r, lmo_r, lmt_r;
    logic [3:0] lso_nxt_s, lst_nxt_s, lmo_nxt_s, lmt_nxt_s;
    logic       lap_active_r, lap_active_nxt_s;
    logic       ss_prev_r, lap_prev_r, clear_prev_r;
    logic       clear_edge_s, ss_raw_s, lap_raw_s;
    logic       ss_edge_s, lap_edge_s, any_edge_s;
    logic       count_en_s, at_limit_s;
`ifdef STOPWATCH_WRAP_EN
    logic       wrap_pulse_s;
`endif

    // Button edge detection with priority clear > startStop > lap.
    always_comb begin
        clear_edge_s = clear & ~clear_prev_r;
        ss_raw_s     = startStop & ~ss_prev_r;
        lap_raw_s    = lap & ~lap_prev_r;
        // Any raw edge suppresses a same-cycle tick, even if the edge loses priority.
        any_edge_s   = clear_edge_s | ss_raw_s | lap_raw_s;
        ss_edge_s    = ss_raw_s & ~clear_edge_s;
        lap_edge_s   = lap_raw_s & ~clear_edge_s & ~ss_raw_s;
        count_en_s   = tick & ~any_edge_s & (state_r == ST_RUN);
        at_limit_s   = (mt_r == MAX_MIN_TENS) && (mo_r == MAX_MIN_ONES) &&
                       (st_r == 4'd5) && (so_r == 4'd9);
    end

    // Next state, live count and lap latch.
    always_comb begin
        state_nxt_s      = state_r;
        so_nxt_s         = so_r;
        st_nxt_s         = st_r;
        mo_nxt_s         = mo_r;
        mt_nxt_s         = mt_r;
        lso_nxt_s        = lso_r;
        lst_nxt_s        = lst_r;
        lmo_nxt_s        = lmo_r;
        lmt_nxt_s        = lmt_r;
        lap_active_nxt_s = lap_active_r;
`ifdef STOPWATCH_WRAP_EN
        wrap_pulse_s     = 1'b0;
`endif
        if (clear_edge_s) begin
            state_nxt_s      = ST_IDLE;
            so_nxt_s         = 4'd0;
            st_nxt_s         = 4'd0;
            mo_nxt_s         = 4'd0;
            mt_nxt_s         = 4'd0;
            lso_nxt_s        = 4'd0;
            lst_nxt_s        = 4'd0;
            lmo_nxt_s        = 4'd0;
            lmt_nxt_s        = 4'd0;
            lap_active_nxt_s = 1'b0;
        end else if (ss_edge_s) begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_RUN;
                ST_RUN:   state_nxt_s = ST_PAUSE;
                ST_PAUSE: state_nxt_s = ST_RUN;
                ST_DONE:  state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end else if (lap_edge_s) begin
            if ((state_r == ST_RUN) || (state_r == ST_PAUSE)) begin
                if (lap_active_r) begin
                    lap_active_nxt_s = 1'b0;
                end else begin
                    lso_nxt_s        = so_r;
                    lst_nxt_s        = st_r;
                    lmo_nxt_s        = mo_r;
                    lmt_nxt_s        = mt_r;
                    lap_active_nxt_s = 1'b1;
                end
            end else begin
                lap_active_nxt_s = lap_active_r;
            end
        end else if (count_en_s) begin
            if (at_limit_s) begin
`ifdef STOPWATCH_WRAP_EN
                so_nxt_s     = 4'd0;
                st_nxt_s     = 4'd0;
                mo_nxt_s     = 4'd0;
                mt_nxt_s     = 4'd0;
                wrap_pulse_s = 1'b1;
`else
                state_nxt_s  = ST_DONE;
`endif
            end else if (so_r != 4'd9) begin
                so_nxt_s = so_r + 4'd1;
            end else begin
                so_nxt_s = 4'd0;
                if (st_r != 4'd5) begin
                    st_nxt_s = st_r + 4'd1;
                end else begin
                    st_nxt_s = 4'd0;
                    if (mo_r != 4'd9) begin
                        mo_nxt_s = mo_r + 4'd1;
                    end else begin
                        mo_nxt_s = 4'd0;
                        mt_nxt_s = mt_r + 4'd1;
                    end
                end
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, count, edge history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            so_r         <= 4'd0;
            st_r         <= 4'd0;
            mo_r         <= 4'd0;
            mt_r         <= 4'd0;
            lso_r        <= 4'd0;
            lst_r        <= 4'd0;
            lmo_r        <= 4'd0;
            lmt_r        <= 4'd0;
            lap_active_r <= 1'b0;
            // Previous levels start high so a button held through reset does not fire.
            ss_prev_r    <= 1'b1;
            lap_prev_r   <= 1'b1;
            clear_prev_r <= 1'b1;
            dividerRst   <= 1'b1;
            running      <= 1'b0;
            lapActive    <= 1'b0;
            secOnes      <= 4'd0;
            secTens      <= 4'd0;
            minOnes      <= 4'd0;
            minTens      <= 4'd0;
            overflow     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            so_r         <= so_nxt_s;
            st_r         <= st_nxt_s;
            mo_r         <= mo_nxt_s;
            mt_r         <= mt_nxt_s;
            lso_r        <= lso_nxt_s;
            lst_r        <= lst_nxt_s;
            lmo_r        <= lmo_nxt_s;
            lmt_r        <= lmt_nxt_s;
            lap_active_r <= lap_active_nxt_s;
            ss_prev_r    <= startStop;
            lap_prev_r   <= lap;
            clear_prev_r <= clear;
            // Outputs follow the next-state values, so a change appears one cycle after its cause.
            dividerRst   <= (state_nxt_s != ST_RUN);
            running      <= (state_nxt_s == ST_RUN);
            lapActive    <= lap_active_nxt_s;
            secOnes      <= lap_active_nxt_s ? lso_nxt_s : so_nxt_s;
            secTens      <= lap_active_nxt_s ? lst_nxt_s : st_nxt_s;
            minOnes      <= lap_active_nxt_s ? lmo_nxt_s : mo_nxt_s;
            minTens      <= lap_active_nxt_s ? lmt_nxt_s : mt_nxt_s;
`ifdef STOPWATCH_WRAP_EN
            overflow     <= wrap_pulse_s;
`else
            overflow     <= (state_nxt_s == ST_DONE);
`endif
        end
    end

endmodule

// File: tb/tb_stopwatch_controller.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_controller
//   Scoreboard bench for stopwatch_controller. The stimulus side drives the
//   inputs for each cycle. It advances a reference model that keeps time as
//   whole seconds, and it queues the expected outputs for that cycle. A
//   monitor pops the queued outputs and compares them with the DUT outputs
//   every cycle.
// -----------------------------------------------------------------------------
module tb_stopwatch_controller;

    localparam int MAXM  = 10;
    localparam int LIMIT = MAXM * 60 + 59;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       startStop = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic       dividerRst, running, lapActive, overflow;
    logic [3:0] secOnes, secTens, minOnes, minTens;

    stopwatch_controller #(.MAX_MINUTES(MAXM)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .startStop  (startStop),
        .lap        (lap),
        .clear      (clear),
        .dividerRst (dividerRst),
        .running    (running),
        .lapActive  (lapActive),
        .secOnes    (secOnes),
        .secTens    (secTens),
        .minOnes    (minOnes),
        .minTens    (minTens),
        .overflow   (overflow)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int cyc = 0;
    // Cycle counter used to match scoreboard entries to edges.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [19:0] exp;
    } item_t;

    item_t sb_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model state: time kept as plain seconds.
    int m_mode  = M_IDLE;
    int m_secs  = 0;
    int m_lap   = 0;
    bit m_lapon = 1'b0;
    bit m_ovf   = 1'b0;
    bit p_s = 1'b1, p_l = 1'b1, p_c = 1'b1;

    // Current button levels held by the stimulus.
    bit ss_l = 1'b0, lap_l = 1'b0, clr_l = 1'b0;

    function automatic logic [19:0] expected_vec();
        int d, m, s;
        d = m_lapon ? m_lap : m_secs;
        m = d / 60;
        s = d % 60;
        return {(m_mode == M_RUN), (m_mode != M_RUN), m_lapon, m_ovf,
                4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic drive(input bit r, input bit t, input bit s, input bit l, input bit c);
        bit    e_c, e_s, e_l, pulse;
        item_t it;
        @(posedge clk);
        #1;
        rst = r; tick = t; startStop = s; lap = l; clear = c;
        if (r) begin
            m_mode = M_IDLE; m_secs = 0; m_lap = 0; m_lapon = 1'b0; m_ovf = 1'b0;
            p_s = 1'b1; p_l = 1'b1; p_c = 1'b1;
        end else begin
            e_c = c && !p_c;
            e_s = s && !p_s;
            e_l = l && !p_l;
            p_c = c; p_s = s; p_l = l;
            pulse = 1'b0;
            if (e_c) begin
                m_mode = M_IDLE; m_secs = 0; m_lap = 0; m_lapon = 1'b0;
            end else if (e_s) begin
                if (m_mode == M_RUN) m_mode = M_PAUSE;
                else if (m_mode != M_DONE) m_mode = M_RUN;
            end else if (e_l) begin
                if (m_mode == M_RUN || m_mode == M_PAUSE) begin
                    if (m_lapon) m_lapon = 1'b0;
                    else begin
                        m_lap = m_secs;
                        m_lapon = 1'b1;
                    end
                end
            end else if (t && m_mode == M_RUN) begin
                if (m_secs == LIMIT) begin
`ifdef STOPWATCH_WRAP_EN
                    m_secs = 0;
                    pulse = 1'b1;
`else
                    m_mode = M_DONE;
`endif
                end else begin
                    m_secs++;
                end
            end
`ifdef STOPWATCH_WRAP_EN
            m_ovf = pulse;
`else
            m_ovf = (m_mode == M_DONE);
`endif
        end
        it.due = cyc + 1;
        it.exp = expected_vec();
        sb_q.push_back(it);
    endtask

    task automatic go(input bit t);
        drive(1'b0, t, ss_l, lap_l, clr_l);
    endtask

    // which: 0 = startStop, 1 = lap, 2 = clear
    task automatic press(input int which);
        if (which == 0) ss_l = 1'b1;
        else if (which == 1) lap_l = 1'b1;
        else clr_l = 1'b1;
        go(1'b0);
        ss_l = 1'b0; lap_l = 1'b0; clr_l = 1'b0;
        go(1'b0);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            go(1'b1);
            go(1'b0);
            go(1'b0);
            go(1'b0);
        end
    endtask

    // Monitor: compare every queued expectation when its cycle comes due.
    always @(posedge clk) begin
        item_t       it;
        logic [19:0] got;
        #3;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            it  = sb_q.pop_front();
            got = {running, dividerRst, lapActive, overflow, minTens, minOnes, secTens, secOnes};
            checks++;
            if (got !== it.exp) begin
                failures++;
                $display("FAIL outputs cyc=%0d got run/divrst/lap/ovf=%b%b%b%b %h%h:%h%h expected %b%b%b%b %h%h:%h%h",
                         cyc, got[19], got[18], got[17], got[16], got[15:12], got[11:8], got[7:4], got[3:0],
                         it.exp[19], it.exp[18], it.exp[17], it.exp[16],
                         it.exp[15:12], it.exp[11:8], it.exp[7:4], it.exp[3:0]);
            end
        end
    end

    initial begin
        // Reset with startStop held; releasing reset must not start the watch.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ss_l = 1'b1;
        for (int i = 0; i < 4; i++) go(1'b0);
        go(1'b1);
        ss_l = 1'b0;
        go(1'b0);

        // Start and count 75 seconds.
        press(0);
        run_ticks(75);

        // Pause at 00:10, ticks ignored, resume.
        press(2); press(0); run_ticks(10);
        press(0); run_ticks(5);
        press(0); run_ticks(1);

        // Lap freeze at 00:20, run on, release at 00:50.
        press(2); press(0); run_ticks(20);
        press(1); run_ticks(30);
        press(1); run_ticks(2);

        // All three edges and a tick in one cycle at 02:03.
        press(2); press(0); run_ticks(123);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        go(1'b0); go(1'b1); go(1'b0);

        // Reach the limit, then keep ticking, lap and start/stop at the limit.
        press(2); press(0); run_ticks(LIMIT);
        run_ticks(4);
        press(1); press(0); run_ticks(2);
        press(2); run_ticks(2);

        // Reset asserted mid-run at 00:42.
        press(0); run_ticks(42);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        go(1'b0); go(1'b1);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            bit t, r;
            t = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 15) == 0) ss_l = ~ss_l;
            if ($urandom_range(0, 15) == 0) lap_l = ~lap_l;
            if ($urandom_range(0, 47) == 0) clr_l = ~clr_l;
            drive(r, t, ss_l, lap_l, clr_l);
        end

        go(1'b0); go(1'b0);
        @(posedge clk);
        #5;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
